core_result_collector: RTL
==========================

CORE_RESULT_COLLECTOR -- requirements
Module: core_result_collector

Interface
REQ-001 Parameter CORES, default 4, number of attached cores (legal 1..8).
REQ-002 Parameter CNT_W, default 16, cycle-counter width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out_strobe  input  CORES x 4  per-core output strobe bus; bit 2 = output_ready.
REQ-006 result  input  CORES x 8  per-core result port (out_port_2).
REQ-007 clear  input  1  synchronous restart of collection.
REQ-008 core_done  output  CORES  per-core sticky done flag.
REQ-009 rd_sel  input  3  core index for result readback.
REQ-010 rd_data  output  8  latched result of core rd_sel; 0 if rd_sel >= CORES.
REQ-011 total_cycles  output  CNT_W  cycles elapsed until all cores done.
REQ-012 total_primes  output  11  sum of all latched results.
REQ-013 all_done  output  1  level; high in DONE state.
REQ-014 done_pulse  output  1  single-cycle pulse on entry to DONE.

Function
REQ-015 Per core, the block SHALL register output_ready each cycle and detect a falling edge as prev=1 and current=0.
REQ-016 On a detected falling edge of an undone core, the block SHALL latch result[i] and set core_done[i] at that same clock edge.
REQ-017 Falling edges on an already-done core SHALL be ignored; first result wins.
REQ-018 FSM states: COUNT, SUM, DONE.
REQ-019 COUNT: total_cycles SHALL increment by 1 every cycle in which core_done (registered value) is not all ones; saturate at all ones, no wrap.
REQ-020 COUNT -> SUM on the edge following the cycle core_done first reads all ones; accumulator and index cleared to 0.
REQ-021 SUM: one core per cycle, accumulator += latched result[index], index += 1; 11-bit unsigned, no overflow possible (8 x 255 = 2040).
REQ-022 SUM -> DONE on the edge that adds index CORES-1; total_primes loaded with final sum, done_pulse high for exactly that one following cycle.
REQ-023 Latency: all_done SHALL rise exactly CORES+1 edges after core_done first reads all ones.
REQ-024 DONE: outputs held stable; strobe edges ignored; remains until clear or reset.
REQ-025 clear (any state) SHALL return to COUNT and zero core_done, latched results, total_cycles, total_primes, done_pulse; clear wins over a simultaneous strobe edge.
REQ-026 Edge-detect registers SHALL NOT be cleared by clear, so no false edge follows clear.
REQ-027 rd_data SHALL be combinational from latched results and rd_sel.

Reset
REQ-028 reset SHALL asynchronously force state COUNT and all outputs, counters, latched results and edge-detect registers to 0.
REQ-029 reset asserted mid-SUM SHALL abandon the sum; no done_pulse is produced.
REQ-030 On reset release, output_ready already low SHALL NOT produce an edge; already high then falling SHALL.

Structure
REQ-031 Package collector_pkg SHALL hold the state enum, CORES_MAX=8, RESULT_W=8, SUM_W=11, STROBE_READY_BIT=2.
REQ-032 One sub-module, strobe_edge_detect (1-bit falling-edge detector, async reset), instantiated per core via generate.

Verification
REQ-033 Cores 0..3 strobes fall at cycles 10,20,30,40 with results 5,7,3,9 -> core_done fills in order; total_cycles=40 (+/-0 per REQ-019 counting); total_primes=24; all_done rises 5 edges after core_done=4'b1111.
REQ-034 Core 1 strobes twice, results 7 then 99 -> rd_data for rd_sel=1 stays 7.
REQ-035 All four results 255 -> total_primes=1020; CORES=8 with all 255 -> 2040, no overflow.
REQ-036 Never finish one core for 70000 cycles -> total_cycles saturates at 16'hFFFF, all_done stays 0.
REQ-037 reset asserted during SUM, then released -> all outputs 0, no done_pulse; clear coincident with a strobe edge -> core_done stays 0.
REQ-038 Strobe held low through reset release -> no core_done set.

Source files
------------

// File: rtl/collector_pkg.sv
// collector_pkg: shared types and constants for the core result collector.
package collector_pkg;
    localparam int CORES_MAX        = 8;
    localparam int RESULT_W         = 8;
    localparam int SUM_W            = 11;
    localparam int STROBE_READY_BIT = 2;
    typedef enum logic [1:0] {ST_COUNT, ST_SUM, ST_DONE} state_e;
endpackage

// File: rtl/strobe_edge_detect.sv
// strobe_edge_detect: 1-bit falling-edge detector on a per-core ready line.
module strobe_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic ready_i,
    output logic fall_o
);
    logic prev_q;
    // Remember last cycle's ready level; cleared only by reset so clear cannot fake an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= ready_i;
    end
    assign fall_o = prev_q & ~ready_i;
endmodule

// File: rtl/core_result_collector.sv
// core_result_collector: latches first result per core, counts cycles to completion, then sums results.
module core_result_collector
    import collector_pkg::*;
#(
    parameter int CORES = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CORES*4-1:0]        out_strobe,
    input  logic [CORES*RESULT_W-1:0] result,
    input  logic                      clear,
    output logic [CORES-1:0]          core_done,
    input  logic [2:0]                rd_sel,
    output logic [RESULT_W-1:0]       rd_data,
    output logic [CNT_W-1:0]          total_cycles,
    output logic [SUM_W-1:0]          total_primes,
    output logic                      all_done,
    output logic                      done_pulse
);
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SUM_W-1:0]      acc_q, acc_d, tot_q, tot_d;
    logic [2:0]            idx_q, idx_d;
    logic                  pulse_q, pulse_d;
    logic [CORES-1:0]      done_q, done_d, fall;
    logic [RESULT_W-1:0]   res_q [CORES];
    logic [RESULT_W-1:0]   res_d [CORES];
    logic [RESULT_W-1:0]   sel_res;
    logic                  unused_strobe;

    // Only the ready bit of each strobe nibble is meaningful.
    assign unused_strobe = ^out_strobe;

    for (genvar g = 0; g < CORES; g++) begin : g_edge
        strobe_edge_detect u_edge (
            .clk     (clk),
            .reset   (reset),
            .ready_i (out_strobe[g*4+STROBE_READY_BIT]),
            .fall_o  (fall[g])
        );
    end

    // Next-state: latch first results, count cycles, then sum one core per cycle; clear overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        tot_d   = tot_q;
        pulse_d = 1'b0;
        done_d  = done_q;
        res_d   = res_q;
        sel_res = '0;
        for (int i = 0; i < CORES; i++)
            if (idx_q == 3'(i)) sel_res = res_q[i];
        case (state_q)
            ST_COUNT: begin
                for (int i = 0; i < CORES; i++)
                    if (fall[i] && !done_q[i]) begin
                        done_d[i] = 1'b1;
                        res_d[i]  = result[i*RESULT_W +: RESULT_W];
                    end
                if (&done_q) begin
                    state_d = ST_SUM;
                    acc_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SUM: begin
                acc_d = acc_q + SUM_W'(sel_res);
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'(CORES-1)) begin
                    state_d = ST_DONE;
                    tot_d   = acc_q + SUM_W'(sel_res);
                    pulse_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
            tot_d   = '0;
            pulse_d = 1'b0;
            done_d  = '0;
            res_d   = '{default: '0};
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            tot_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= '0;
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            tot_q   <= tot_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    // Readback mux; indices beyond the core count read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CORES; i++)
            if (rd_sel == 3'(i)) rd_data = res_q[i];
    end

    assign core_done    = done_q;
    assign total_cycles = cnt_q;
    assign total_primes = tot_q;
    assign done_pulse   = pulse_q;
    assign all_done     = (state_q == ST_DONE);
endmodule
